note_scheduler: RTL and testbench
=================================

# note_scheduler

Owns the single buzzer note channel and decides who drives it: the live 8-key keyboard, or an autoplay sequencer that steps through a synchronous song ROM one beat per note. Keys are decoded, debounced, and given priority. A held key pauses the song, and the song resumes when the key is released. The block sits between the key inputs and the tone generator, and it also produces the matching one-hot LED pattern.

## Interface
- BEAT_CYCLES, 25_000_000, clock cycles per song note (≥2)
- DEBOUNCE_CYCLES, 200_000, consecutive stable cycles required to accept a key change (≥1)
- SONG_LEN, 32, number of song ROM entries (≥1, ≤2^ADDR_W)
- ADDR_W, 5, song ROM address width
- clk  in  1  system clock; one clock domain
- rst  in  1  synchronous, active-high reset
- keys  in  8  raw key lines; bits 7:1 map to notes 7..1; bit 0 is ignored
- play_start  in  1  single-cycle pulse; (re)starts the song at address 0
- play_stop  in  1  single-cycle pulse; aborts the song
- song_addr  out  ADDR_W  song ROM address (registered)
- song_note  in  4  ROM data, valid the cycle after song_addr changes
- note_out  out  4  note to the tone generator: 0 = rest, 1..7 = do..si (registered)
- led_out  out  8  one-hot of note_out (bit n for note n); all zeros for a rest
- src_song  out  1  1 when note_out is driven by the song
- busy  out  1  1 when the sequencer is not in IDLE

## Operation
- Key decode: the value of keys[7:1] is treated as follows.
  - Exactly one bit set at position n gives note n.
  - Any other value, including all zeros or multiple bits set, gives 0.
- Debounce: the decoded value is registered. A counter clears whenever the registered value changes. The stable key value updates after DEBOUNCE_CYCLES consecutive equal samples.
- Arbitration: a nonzero stable key always wins the channel. In that case note_out = key and src_song = 0.
- FSM states:
  - IDLE: the song is not playing. note_out = stable key.
    - On play_start, song_addr ← 0 and go to FETCH.
  - FETCH: lasts exactly 2 cycles. The address is presented in cycle 1 and song_note is sampled at the end of cycle 2.
    - If the sampled value is 4'hF (end marker), go to IDLE.
    - Otherwise latch the note (0 = rest; values 8..14 are treated as rest) and go to PLAY.
  - PLAY: the beat counter counts BEAT_CYCLES cycles, then the sequencer advances:
    - at song_addr = SONG_LEN-1, go to IDLE;
    - otherwise song_addr+1 and go to FETCH.
- Key preemption during FETCH or PLAY:
  - The beat counter freezes while the stable key is nonzero.
  - A FETCH in progress still completes.
  - The song note is shown again on the cycle after the key releases, and the count resumes from the frozen value.
- During FETCH, note_out holds the previous song note, so there is no glitch to rest.
- Priority of controls:
  - play_stop beats play_start when both arrive in the same cycle.
  - play_stop while busy goes to IDLE on the next edge.
  - play_start while busy restarts at address 0 and goes to FETCH.
  - play_stop while idle is ignored.
- src_song = 1 only when busy is high, the stable key is 0, and a song note has been latched since the last play_start.

## Timing
- Reset values: song_addr = 0, note_out = 0, led_out = 0, src_song = 0, busy = 0, FSM = IDLE. The stable key, the debounce counter and the beat counter also clear.
- Reset mid-song takes effect on the next edge, with no partial note.
- Key change to note_out: exactly DEBOUNCE_CYCLES+2 cycles, provided keys stay constant for that whole window. A shorter pulse produces no change.
- Start to first song note: play_start is sampled at edge 0, and note_out shows entry 0 after edge 3.
- Note period with no keys held: BEAT_CYCLES+2 cycles.
- led_out is combinational from note_out, so it carries no extra latency.

## Configuration
- NOTE_SCHED_LOOP_EN:
  - When defined, completing entry SONG_LEN-1 wraps to address 0 and goes to FETCH. The sequencer stops only on play_stop, the 4'hF marker, or reset.
  - When undefined, the sequencer returns to IDLE after the last entry.

## Structure
- Shared package note_pkg:
  - note codes NOTE_REST = 0, NOTE_DO..NOTE_SI = 1..7, NOTE_END = 4'hF;
  - the FSM state enum {IDLE, FETCH, PLAY};
  - a note-to-LED one-hot function.
- One sub-module, key_debounce: holds the decode register, the stability counter and the stable key output. It is parameterised by DEBOUNCE_CYCLES.

## Test plan
Parameters for all scenarios: BEAT_CYCLES = 4, DEBOUNCE_CYCLES = 3, SONG_LEN = 4. ROM contents = {3, 0, 5, 1}.
- Reset then idle: every output is 0. keys = 8'b00001000 held for 10 cycles → note_out = 3 and led_out = 8'b00001000 exactly 5 cycles after the change.
- Bounce and invalid values: keys toggled every 2 cycles → note_out stays 0. keys = 8'b00000110 → note_out = 0. keys = 8'b00000001 → note_out = 0.
- Autoplay: pulse play_start → note_out shows 3, 0, 5, 1 at 6-cycle spacing with src_song = 1. busy falls after the last beat; note_out is then 0 and song_addr = 3.
- Preemption: key 7 held during the second song note → note_out = 7 and src_song = 0, with the beat count frozen. On release, note 0 resumes for its remaining beats and then note 5 follows.
- Control collision: play_start and play_stop in the same cycle while busy → IDLE next edge. ROM entry 1 = 4'hF → the sequencer stops after note 3.
- With NOTE_SCHED_LOOP_EN defined: after entry 3, song_addr wraps to 0 and note 3 replays. Asserting rst mid-PLAY → all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/note_pkg.sv
// Shared note codes, sequencer states and the note-to-LED helper for note_scheduler.
package note_pkg;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_DO   = 4'd1;
  localparam logic [3:0] NOTE_RE   = 4'd2;
  localparam logic [3:0] NOTE_MI   = 4'd3;
  localparam logic [3:0] NOTE_FA   = 4'd4;
  localparam logic [3:0] NOTE_SOL  = 4'd5;
  localparam logic [3:0] NOTE_LA   = 4'd6;
  localparam logic [3:0] NOTE_SI   = 4'd7;
  localparam logic [3:0] NOTE_END  = 4'hF;

  typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

  // One-hot LED for notes 1..7; rests and out-of-range codes light nothing.
  function automatic logic [7:0] note_to_led(input logic [3:0] note);
    note_to_led = 8'h00;
    if (note != NOTE_REST && note <= NOTE_SI) note_to_led[note[2:0]] = 1'b1;
  endfunction

endpackage

// File: rtl/note_scheduler_if.sv
// Key, control, song ROM and tone-generator signals of note_scheduler.
// slave = scheduler side, master = environment (keys, controls, ROM, tone generator).
interface note_scheduler_if #(
  parameter int ADDR_W = 5
) ();
  logic [7:0]        keys;
  logic              play_start;
  logic              play_stop;
  logic [ADDR_W-1:0] song_addr;
  logic [3:0]        song_note;
  logic [3:0]        note_out;
  logic [7:0]        led_out;
  logic              src_song;
  logic              busy;

  modport master (
    output keys, play_start, play_stop, song_note,
    input  song_addr, note_out, led_out, src_song, busy
  );

  modport slave (
    input  keys, play_start, play_stop, song_note,
    output song_addr, note_out, led_out, src_song, busy
  );
endinterface

// File: rtl/key_debounce.sv
// Decodes keys[7:1] to a note (exactly one key down, otherwise 0) and only
// accepts a new value after DEBOUNCE_CYCLES consecutive equal samples.
module key_debounce import note_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 200_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] key_bits,
  output logic [3:0] stable_key
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       dec;
  logic [3:0]       dec_q;
  logic [CNT_W-1:0] cnt;

  // Decode: one key gives its note, chords and no key give rest.
  always_comb begin
    dec = NOTE_REST;
    if ($onehot(key_bits)) begin
      for (int i = 0; i < 7; i++) begin
        if (key_bits[i]) dec = 4'(i + 1);
      end
    end
  end

  // Sample register plus stability counter; any change in the sample restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q      <= NOTE_REST;
      cnt        <= '0;
      stable_key <= NOTE_REST;
    end else if (dec != dec_q) begin
      dec_q <= dec;
      cnt   <= '0;
    end else if (dec_q != stable_key) begin
      if (cnt == CNT_LAST) begin
        stable_key <= dec_q;
        cnt        <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/note_scheduler.sv
// Buzzer note channel arbiter: debounced keyboard vs. song ROM sequencer.
// A held key owns the channel and freezes the beat count; releasing it resumes the song.
// Optional macro NOTE_SCHED_LOOP_EN: wrap to entry 0 after the last entry instead of stopping.
module note_scheduler import note_pkg::*; #(
  parameter int BEAT_CYCLES     = 25_000_000,
  parameter int DEBOUNCE_CYCLES = 200_000,
  parameter int SONG_LEN        = 32,
  parameter int ADDR_W          = 5
) (
  input logic              clk,
  input logic              rst,
  note_scheduler_if.slave  bus
);

  localparam int BEAT_W = $clog2(BEAT_CYCLES);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic              fetch_ph, fetch_d;
  logic [BEAT_W-1:0] beat_cnt, beat_d;
  logic [3:0]        song_reg, song_d;
  logic              have_note, have_d;
  logic [3:0]        note_q, note_d;
  logic [3:0]        stable_key;
  logic              key_held;
  logic              busy;
  logic              unused_key0;

  assign unused_key0 = bus.keys[0];

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk       (clk),
    .rst       (rst),
    .key_bits  (bus.keys[7:1]),
    .stable_key(stable_key)
  );

  assign key_held = (stable_key != NOTE_REST);
  assign busy     = (state != IDLE);

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      fetch_ph  <= 1'b0;
      beat_cnt  <= '0;
      song_reg  <= NOTE_REST;
      have_note <= 1'b0;
      note_q    <= NOTE_REST;
    end else begin
      state     <= state_d;
      addr      <= addr_d;
      fetch_ph  <= fetch_d;
      beat_cnt  <= beat_d;
      song_reg  <= song_d;
      have_note <= have_d;
      note_q    <= note_d;
    end
  end

  // Next state: stop beats start; FETCH runs two cycles even under a key; PLAY beat freezes under a key.
  always_comb begin
    state_d = state;
    addr_d  = addr;
    fetch_d = fetch_ph;
    beat_d  = beat_cnt;
    song_d  = song_reg;
    have_d  = have_note;
    if (bus.play_stop) begin
      if (busy) begin
        state_d = IDLE;
        fetch_d = 1'b0;
        beat_d  = '0;
        have_d  = 1'b0;
      end
    end else if (bus.play_start) begin
      state_d = FETCH;
      addr_d  = '0;
      fetch_d = 1'b0;
      beat_d  = '0;
      have_d  = 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (!fetch_ph) begin
            fetch_d = 1'b1;
          end else begin
            fetch_d = 1'b0;
            if (bus.song_note == NOTE_END) begin
              state_d = IDLE;
            end else begin
              song_d  = (bus.song_note <= NOTE_SI) ? bus.song_note : NOTE_REST;
              have_d  = 1'b1;
              beat_d  = '0;
              state_d = PLAY;
            end
          end
        end
        PLAY: begin
          if (!key_held) begin
            if (beat_cnt == BEAT_LAST) begin
              beat_d = '0;
              if (addr == ADDR_LAST) begin
`ifdef NOTE_SCHED_LOOP_EN
                addr_d  = '0;
                state_d = FETCH;
`else
                state_d = IDLE;
`endif
              end else begin
                addr_d  = addr + 1'b1;
                state_d = FETCH;
              end
            end else begin
              beat_d = beat_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Channel owner: key first, then the latched song note (held through FETCH), else rest.
  always_comb begin
    note_d = NOTE_REST;
    if (key_held)               note_d = stable_key;
    else if (busy && have_note) note_d = song_reg;
  end

  assign bus.song_addr = addr;
  assign bus.note_out  = note_q;
  assign bus.led_out   = note_to_led(note_q);
  assign bus.src_song  = busy && !key_held && have_note;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler: BEAT=4, DEBOUNCE=3, SONG_LEN=4, ROM {3,0,5,1}.
module tb_note_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] rom [4];

  always #5 clk = ~clk;

  note_scheduler_if #(.ADDR_W(2)) bus ();

  note_scheduler #(
    .BEAT_CYCLES(4), .DEBOUNCE_CYCLES(3), .SONG_LEN(4), .ADDR_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Synchronous song ROM
  always @(posedge clk) bus.song_note <= rom[bus.song_addr];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_song();
    bus.play_start = 1'b1;
    tick(1);
    bus.play_start = 1'b0;
  endtask

  task automatic stop_song();
    bus.play_stop = 1'b1;
    tick(1);
    bus.play_stop = 1'b0;
  endtask

  initial begin
    rom[0] = 4'd3; rom[1] = 4'd0; rom[2] = 4'd5; rom[3] = 4'd1;
    bus.keys = 8'h00; bus.play_start = 1'b0; bus.play_stop = 1'b0; bus.song_note = 4'd0;

    // Reset
    tick(3);
    chk("rst_note", 32'(bus.note_out), 32'd0);
    chk("rst_led", 32'(bus.led_out), 32'd0);
    chk("rst_src", 32'(bus.src_song), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_addr", 32'(bus.song_addr), 32'd0);
    rst = 1'b0;
    tick(2);

    // Key 3: visible exactly 5 edges after the change
    bus.keys = 8'b0000_1000;
    tick(4);
    chk("key_early", 32'(bus.note_out), 32'd0);
    tick(1);
    chk("key_note", 32'(bus.note_out), 32'd3);
    chk("key_led", 32'(bus.led_out), 32'h08);
    chk("key_src", 32'(bus.src_song), 32'd0);
    tick(5);
    chk("key_hold", 32'(bus.note_out), 32'd3);
    bus.keys = 8'h00;
    tick(6);
    chk("key_rel", 32'(bus.note_out), 32'd0);

    // Bounce: toggling every 2 cycles never settles
    for (int i = 0; i < 6; i++) begin
      bus.keys = (i % 2 == 0) ? 8'h10 : 8'h00;
      tick(2);
      chk("bounce", 32'(bus.note_out), 32'd0);
    end
    bus.keys = 8'h00;
    tick(6);
    bus.keys = 8'b0000_0110;
    tick(6);
    chk("chord", 32'(bus.note_out), 32'd0);
    bus.keys = 8'b0000_0001;
    tick(6);
    chk("bit0", 32'(bus.note_out), 32'd0);
    bus.keys = 8'h00;
    tick(6);

    // Autoplay: entry 0 after edge 3, then 6-cycle spacing
    start_song();
    tick(2);
    chk("ap_pre", 32'(bus.note_out), 32'd0);
    chk("ap_busy", 32'(bus.busy), 32'd1);
    tick(1);
    chk("ap_n0", 32'(bus.note_out), 32'd3);
    chk("ap_src0", 32'(bus.src_song), 32'd1);
    chk("ap_led0", 32'(bus.led_out), 32'h08);
    tick(6);
    chk("ap_n1", 32'(bus.note_out), 32'd0);
    chk("ap_src1", 32'(bus.src_song), 32'd1);
    chk("ap_led1", 32'(bus.led_out), 32'd0);
    tick(6);
    chk("ap_n2", 32'(bus.note_out), 32'd5);
    tick(6);
    chk("ap_n3", 32'(bus.note_out), 32'd1);
    chk("ap_led3", 32'(bus.led_out), 32'h02);
    tick(2);
    chk("ap_lastbeat", 32'(bus.busy), 32'd1);
    tick(1);
`ifdef NOTE_SCHED_LOOP_EN
    chk("loop_busy", 32'(bus.busy), 32'd1);
    chk("loop_addr", 32'(bus.song_addr), 32'd0);
    tick(3);
    chk("loop_n0", 32'(bus.note_out), 32'd3);
    chk("loop_src", 32'(bus.src_song), 32'd1);
    stop_song();
    chk("loop_stop", 32'(bus.busy), 32'd0);
    tick(1);
    chk("loop_stop_note", 32'(bus.note_out), 32'd0);
`else
    chk("ap_done_busy", 32'(bus.busy), 32'd0);
    chk("ap_done_addr", 32'(bus.song_addr), 32'd3);
    chk("ap_done_src", 32'(bus.src_song), 32'd0);
    tick(1);
    chk("ap_done_note", 32'(bus.note_out), 32'd0);
`endif
    tick(3);

    // Preemption: key 7 during the second note freezes the beat
    start_song();
    tick(6);
    bus.keys = 8'h80;
    tick(3);
    chk("pre_song", 32'(bus.note_out), 32'd0);
    chk("pre_song_src", 32'(bus.src_song), 32'd1);
    tick(2);
    chk("pre_key", 32'(bus.note_out), 32'd7);
    chk("pre_key_src", 32'(bus.src_song), 32'd0);
    chk("pre_key_led", 32'(bus.led_out), 32'h80);
    tick(3);
    chk("pre_addr", 32'(bus.song_addr), 32'd1);
    bus.keys = 8'h00;
    tick(3);
    chk("pre_frozen", 32'(bus.note_out), 32'd7);
    chk("pre_frozen_addr", 32'(bus.song_addr), 32'd1);
    tick(2);
    chk("pre_resume", 32'(bus.note_out), 32'd0);
    chk("pre_resume_src", 32'(bus.src_song), 32'd1);
    tick(3);
    chk("pre_fetch_hold", 32'(bus.note_out), 32'd0);
    tick(1);
    chk("pre_next", 32'(bus.note_out), 32'd5);
    stop_song();
    chk("pre_stop", 32'(bus.busy), 32'd0);
    tick(3);

    // Collision: stop wins over start while busy
    start_song();
    tick(4);
    bus.play_start = 1'b1;
    bus.play_stop  = 1'b1;
    tick(1);
    bus.play_start = 1'b0;
    bus.play_stop  = 1'b0;
    chk("coll_busy", 32'(bus.busy), 32'd0);
    tick(1);
    chk("coll_note", 32'(bus.note_out), 32'd0);
    chk("coll_src", 32'(bus.src_song), 32'd0);
    tick(2);

    // End marker in entry 1
    rom[1] = 4'hF;
    start_song();
    tick(3);
    chk("end_n0", 32'(bus.note_out), 32'd3);
    tick(4);
    chk("end_fetch", 32'(bus.busy), 32'd1);
    tick(1);
    chk("end_idle", 32'(bus.busy), 32'd0);
    tick(1);
    chk("end_note", 32'(bus.note_out), 32'd0);
    rom[1] = 4'd0;
    tick(2);

    // Reset mid-PLAY
    start_song();
    tick(5);
    chk("mid_play", 32'(bus.note_out), 32'd3);
    rst = 1'b1;
    tick(1);
    chk("mrst_note", 32'(bus.note_out), 32'd0);
    chk("mrst_led", 32'(bus.led_out), 32'd0);
    chk("mrst_src", 32'(bus.src_song), 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_addr", 32'(bus.song_addr), 32'd0);
    rst = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
